if_id_fetch: RTL and testbench
==============================

# if_id_fetch

Instruction-fetch front end that sits directly downstream of the PC register and feeds the IF/ID pipeline register of the 5-stage core. Each cycle it issues an instruction-memory request at the current PC and tells the PC register when it may advance. Returned words are latched into IF/ID together with their PC and PC+4. A one-entry skid buffer, a hazard-stall input and a branch-flush input make sure no instruction is lost, duplicated or executed down a squashed path.

## Interface
- WIDTH, 32, address/data width
- NOP_INSTR, 32'h0000_0000, encoding inserted as a bubble
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  core run enable; low forces IDLE and a bubble
- pc_i  in  WIDTH  current PC from the PC register
- pc_write_o  out  1  PC register may load its next value this cycle
- stall_i  in  1  hazard-detection stall; IF/ID must hold
- flush_i  in  1  taken branch/jump; squash the fetch path
- imem_req_o  out  1  instruction memory request valid
- imem_addr_o  out  WIDTH  request address
- imem_ready_i  in  1  memory accepts the request and returns data this cycle
- imem_rdata_i  in  WIDTH  instruction word, valid when imem_req_o && imem_ready_i
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_instr_o  out  WIDTH  IF/ID instruction
- ifid_pc_o  out  WIDTH  PC of that instruction
- ifid_pc4_o  out  WIDTH  ifid_pc_o + 4, modulo 2^WIDTH

## Operation
- States: IDLE, REQ, HOLD, SQUASH.
- Fetch event: imem_req_o && imem_ready_i in state REQ.
- IDLE
  - imem_req_o=0; pc_write_o=0.
  - Moves to REQ on start_i=1.
- REQ
  - imem_req_o=1; imem_addr_o=pc_i.
  - Each cycle, addr_q <= pc_i.
  - No fetch event: pc_write_o=0, so pc_i stays stable for the outstanding request.
  - Fetch event with stall_i=0: IF/ID <= {1, rdata, pc_i, pc_i+4}; pc_write_o=1; stay in REQ.
  - Fetch event with stall_i=1: skid buffer <= {rdata, pc_i}; pc_write_o=1; IF/ID holds; go to HOLD.
- HOLD
  - imem_req_o=0; pc_write_o=0.
  - When stall_i=0: IF/ID <= buffer (valid=1); go to REQ.
- SQUASH (entered only when flush_i arrives while a request is pending without ready)
  - imem_req_o=1; imem_addr_o=addr_q.
  - On imem_ready_i the returned data is discarded; go to REQ.
  - pc_write_o=0.
- flush_i=1, any state except IDLE:
  - IF/ID <= {0, NOP_INSTR, 0, 0}, even if stall_i=1.
  - Skid buffer is dropped.
  - pc_write_o=1, so the PC loads the branch target.
  - Next state: SQUASH if in REQ or SQUASH without imem_ready_i; otherwise REQ. Any fetch event in that cycle is discarded.
- Priority: rst_i > start_i=0 > flush_i > stall_i > fetch event.
- start_i=0: next state IDLE, IF/ID cleared to a bubble, buffer dropped, pc_write_o=0. An outstanding request is abandoned; the memory must tolerate req deassertion.
- stall_i with no fetch event: IF/ID holds, request stays pending.

## Timing
- Reset (async, rst_i=1): state=IDLE; ifid_valid_o=0; ifid_instr_o=NOP_INSTR; ifid_pc_o=0; ifid_pc4_o=0; buffer cleared; imem_req_o=0; pc_write_o=0.
- Latency: IF/ID updates on the clock edge that ends the fetch-event cycle.
- Throughput: 1 instruction/cycle with a zero-wait memory (imem_ready_i tied high).
- imem_addr_o stays stable from the first cycle of imem_req_o until imem_ready_i. In REQ this holds because pc_write_o=0; in SQUASH it holds because addr_q is used.
- pc_write_o, imem_req_o and imem_addr_o are combinational from state and inputs; all IF/ID outputs are registered.
- PC+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.

## Structure
- Shared core package:
  - fetch state enum {IDLE, REQ, HOLD, SQUASH}
  - NOP_INSTR constant
  - IF/ID bundle struct {valid, instr, pc, pc4}
- One natural sub-module: if_skid_buf, the one-entry buffer with load/drop/valid. The FSM and IF/ID register stay in the top module.

## Test plan
- Reset mid-run: rst_i=1 while in HOLD -> all outputs at their reset values immediately, without waiting for a clock edge; after release with start_i=1, the first fetch is at the pc_i supplied.
- Zero-wait stream: PC 0x00,0x04,0x08, ready=1 -> IF/ID shows pc 0x00/0x04/0x08 on consecutive cycles with pc4 0x04/0x08/0x0C; pc_write_o=1 every cycle.
- Wait states: ready low 2 cycles at pc=0x10 -> imem_addr_o=0x10 held 3 cycles; pc_write_o=0, 0, then 1; a single IF/ID entry for 0x10.
- Stall during fetch: stall_i=1 when 0x20 returns -> HOLD, IF/ID keeps the prior instruction; after stall_i falls, IF/ID=0x20 and 0x20 is not refetched.
- Flush with pending request: flush_i at pc=0x30, ready low, then ready high -> IF/ID bubble; 0x30 data discarded in SQUASH; next fetch at the target 0x100.
- Simultaneous flush+stall in HOLD -> buffer dropped, IF/ID bubble, state REQ.

Source files
------------

// File: rtl/if_id_fetch_pkg.sv
// Shared fetch front-end types: state encoding, bubble encoding and the IF/ID bundle.
package if_id_fetch_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc4;
  } ifid_t;

  // IF/ID contents for an inserted bubble.
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.valid = 1'b0;
    b.instr = NOP_INSTR;
    b.pc    = '0;
    b.pc4   = '0;
    return b;
  endfunction

  // Real IF/ID entry; pc4 wraps modulo 2^WIDTH.
  function automatic ifid_t ifid_entry(input logic [WIDTH-1:0] instr,
                                       input logic [WIDTH-1:0] pc);
    ifid_t e;
    e.valid = 1'b1;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc + WIDTH'(4);
    return e;
  endfunction

endpackage

// File: rtl/if_id_fetch_skid_buf.sv
// One-entry skid buffer holding an instruction returned while IF/ID is stalled.
module if_skid_buf
  import if_id_fetch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             drop_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  // Next entry: drop wins over load so a flush always empties the buffer.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (drop_i) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_id_fetch.sv
// Instruction-fetch front end: issues imem requests at the PC, gates PC advance,
// and fills the IF/ID register with stall skid buffering and branch squashing.
module if_id_fetch
  import if_id_fetch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_write_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ready_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             ifid_valid_o,
  output logic [WIDTH-1:0] ifid_instr_o,
  output logic [WIDTH-1:0] ifid_pc_o,
  output logic [WIDTH-1:0] ifid_pc4_o
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  ifid_t            ifid_q, ifid_d;

  logic             buf_load;
  logic             buf_drop;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_instr;
  logic [WIDTH-1:0] buf_pc;

  if_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .drop_i  (buf_drop),
    .instr_i (imem_rdata_i),
    .pc_i    (pc_i),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  // Next state, request/PC-advance outputs and IF/ID next value.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ifid_d      = ifid_q;
    pc_write_o  = 1'b0;
    imem_req_o  = 1'b0;
    imem_addr_o = addr_q;
    buf_load    = 1'b0;
    buf_drop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = REQ;
      end

      REQ: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_i;
        addr_d      = pc_i;
        if (flush_i) begin
          ifid_d     = ifid_bubble();
          buf_drop   = 1'b1;
          pc_write_o = 1'b1;
          state_d    = imem_ready_i ? REQ : SQUASH;
        end else if (imem_ready_i) begin
          pc_write_o = 1'b1;
          if (stall_i) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            ifid_d = ifid_entry(imem_rdata_i, pc_i);
          end
        end
      end

      HOLD: begin
        if (flush_i) begin
          ifid_d     = ifid_bubble();
          buf_drop   = 1'b1;
          pc_write_o = 1'b1;
          state_d    = REQ;
        end else if (!stall_i) begin
          ifid_d       = ifid_entry(buf_instr, buf_pc);
          ifid_d.valid = buf_valid;
          buf_drop     = 1'b1;
          state_d      = REQ;
        end
      end

      SQUASH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = addr_q;
        if (flush_i) begin
          ifid_d     = ifid_bubble();
          buf_drop   = 1'b1;
          pc_write_o = 1'b1;
          state_d    = imem_ready_i ? REQ : SQUASH;
        end else if (imem_ready_i) begin
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // Run enable low overrides everything and abandons any request.
    if (!start_i) begin
      state_d    = IDLE;
      ifid_d     = ifid_bubble();
      buf_load   = 1'b0;
      buf_drop   = 1'b1;
      pc_write_o = 1'b0;
      imem_req_o = 1'b0;
    end
  end

  // State, pending-address and IF/ID registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ifid_q  <= ifid_bubble();
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ifid_q  <= ifid_d;
    end
  end

  assign ifid_valid_o = ifid_q.valid;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_pc4_o   = ifid_q.pc4;

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed bench for if_id_fetch with hand-computed expectations.
module tb_if_id_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        pc_write;
  logic        stall;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic        v;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic [31:0] ipc4;

  int n_checks = 0;
  int n_errors = 0;

  if_id_fetch dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .pc_i         (pc),
    .pc_write_o   (pc_write),
    .stall_i      (stall),
    .flush_i      (flush),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ready_i (ready),
    .imem_rdata_i (rdata),
    .ifid_valid_o (v),
    .ifid_instr_o (instr),
    .ifid_pc_o    (ipc),
    .ifid_pc4_o   (ipc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic ev, input logic [31:0] ei,
                            input logic [31:0] ep, input logic [31:0] ep4);
    check({tag, ".valid"}, 32'(v), 32'(ev));
    check({tag, ".instr"}, instr, ei);
    check({tag, ".pc"}, ipc, ep);
    check({tag, ".pc4"}, ipc4, ep4);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
    ready = 1'b0; rdata = '0;
    step(); step();
    check_ifid("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    check("reset.req", 32'(req), 32'd0);
    check("reset.pcw", 32'(pc_write), 32'd0);
    rst = 1'b0;

    // Zero-wait stream.
    start = 1'b1; ready = 1'b1; pc = 32'h00; rdata = 32'hA0;
    #1;
    check("idle.req", 32'(req), 32'd0);
    step();
    check("s0.req", 32'(req), 32'd1);
    check("s0.addr", addr, 32'h00);
    check("s0.pcw", 32'(pc_write), 32'd1);
    step();
    check_ifid("s0", 1'b1, 32'hA0, 32'h00, 32'h04);
    pc = 32'h04; rdata = 32'hA4; #1;
    check("s1.pcw", 32'(pc_write), 32'd1);
    step();
    check_ifid("s1", 1'b1, 32'hA4, 32'h04, 32'h08);
    pc = 32'h08; rdata = 32'hA8; #1;
    check("s2.pcw", 32'(pc_write), 32'd1);
    step();
    check_ifid("s2", 1'b1, 32'hA8, 32'h08, 32'h0C);

    // Wait states at 0x10.
    pc = 32'h10; rdata = 32'hB0; ready = 1'b0; #1;
    check("w0.addr", addr, 32'h10);
    check("w0.pcw", 32'(pc_write), 32'd0);
    step();
    check_ifid("w0.hold", 1'b1, 32'hA8, 32'h08, 32'h0C);
    check("w1.addr", addr, 32'h10);
    check("w1.pcw", 32'(pc_write), 32'd0);
    step();
    ready = 1'b1; #1;
    check("w2.addr", addr, 32'h10);
    check("w2.pcw", 32'(pc_write), 32'd1);
    step();
    check_ifid("w", 1'b1, 32'hB0, 32'h10, 32'h14);

    // Stall during fetch at 0x20.
    pc = 32'h20; rdata = 32'hC0; stall = 1'b1; #1;
    check("st.pcw", 32'(pc_write), 32'd1);
    step();
    check_ifid("st.keep", 1'b1, 32'hB0, 32'h10, 32'h14);
    check("st.hold.req", 32'(req), 32'd0);
    pc = 32'h24; rdata = 32'hDEAD; #1;
    check("st.hold.pcw", 32'(pc_write), 32'd0);
    step();
    check_ifid("st.keep2", 1'b1, 32'hB0, 32'h10, 32'h14);
    stall = 1'b0;
    step();
    check_ifid("st.out", 1'b1, 32'hC0, 32'h20, 32'h24);
    check("st.next.addr", addr, 32'h24);
    rdata = 32'hC4;
    step();
    check_ifid("st.next", 1'b1, 32'hC4, 32'h24, 32'h28);

    // Flush with a pending request at 0x30.
    pc = 32'h30; ready = 1'b0; flush = 1'b1; #1;
    check("fl.pcw", 32'(pc_write), 32'd1);
    check("fl.addr", addr, 32'h30);
    step();
    check_ifid("fl.bubble", 1'b0, 32'h0, 32'h0, 32'h0);
    flush = 1'b0; pc = 32'h100; #1;
    check("sq.req", 32'(req), 32'd1);
    check("sq.addr", addr, 32'h30);
    check("sq.pcw", 32'(pc_write), 32'd0);
    step();
    ready = 1'b1; rdata = 32'hBAD; #1;
    check("sq2.addr", addr, 32'h30);
    check("sq2.pcw", 32'(pc_write), 32'd0);
    step();
    check_ifid("sq.discard", 1'b0, 32'h0, 32'h0, 32'h0);
    rdata = 32'h1000; #1;
    check("tgt.addr", addr, 32'h100);
    step();
    check_ifid("tgt", 1'b1, 32'h1000, 32'h100, 32'h104);

    // Flush together with stall while in HOLD.
    pc = 32'h104; rdata = 32'hE4; stall = 1'b1;
    step();
    check_ifid("fs.hold", 1'b1, 32'h1000, 32'h100, 32'h104);
    flush = 1'b1; #1;
    check("fs.pcw", 32'(pc_write), 32'd1);
    step();
    check_ifid("fs.bubble", 1'b0, 32'h0, 32'h0, 32'h0);
    flush = 1'b0; stall = 1'b0; pc = 32'h200; rdata = 32'hF0; #1;
    check("fs.req", 32'(req), 32'd1);
    check("fs.addr", addr, 32'h200);
    step();
    check_ifid("fs.next", 1'b1, 32'hF0, 32'h200, 32'h204);

    // PC+4 wrap.
    pc = 32'hFFFF_FFFC; rdata = 32'h77;
    step();
    check_ifid("wrap", 1'b1, 32'h77, 32'hFFFF_FFFC, 32'h0);

    // Asynchronous reset while in HOLD.
    pc = 32'h300; rdata = 32'h33; stall = 1'b1;
    step();
    check("rh.req", 32'(req), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_ifid("arst", 1'b0, 32'h0, 32'h0, 32'h0);
    check("arst.req", 32'(req), 32'd0);
    check("arst.pcw", 32'(pc_write), 32'd0);
    rst = 1'b0; stall = 1'b0; pc = 32'h400; rdata = 32'h44;
    step();
    check("rs.addr", addr, 32'h400);
    step();
    check_ifid("rs", 1'b1, 32'h44, 32'h400, 32'h404);

    // Run enable low: request dropped, bubble inserted.
    start = 1'b0; #1;
    check("stop.req", 32'(req), 32'd0);
    check("stop.pcw", 32'(pc_write), 32'd0);
    step();
    check_ifid("stop", 1'b0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
